// File: rtl/pll_phase_step_ctrl.sv
// -----------------------------------------------------------------------------
// pll_phase_step_ctrl
//
// Purpose:
//   Turns one phase-shift request at a time into the phase-port sequence of an
//   ecp5pll. The selected output and direction go out first, with a one-cycle
//   phaseloadreg strobe. Then come req_steps evenly spaced phasestep pulses.
//   The controller then waits for PLL lock to hold steady and reports completion
//   with a one-cycle done pulse. err is set on that pulse if lock never settled.
//   A bookkeeping position counter is kept for each of the four PLL outputs.
//
// Handshake:
//   A request transfers on a rising clk_i edge where req_valid && req_ready.
//   req_ready is high only in IDLE while locked is high. req_valid need not be
//   held and is ignored at all other times. Nothing is queued.
//
// Ports:
//   clk_i        25 MHz PLL reference clock
//   rst_ni       asynchronous active-low reset
//   req_valid    request strobe
//   req_ready    request can be accepted (IDLE && locked)
//   req_sel      target output 0..3
//   req_dir      0 = advance phase, 1 = retard phase
//   req_steps    number of phase steps (0 is legal)
//   locked       PLL lock indicator
//   phasesel     ecp5pll PHASESEL
//   phasedir     ecp5pll PHASEDIR
//   phasestep    ecp5pll PHASESTEP
//   phaseloadreg ecp5pll PHASELOADREG
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle completion pulse
//   err          lock-timeout flag, valid with done, held until the next done
//   phase_pos    four 8-bit position counters, output n at [8n+7:8n]
//   state_dbg_o  current FSM state encoding
// -----------------------------------------------------------------------------
module pll_phase_step_ctrl #(
    parameter int SETUP_CYC       = 2,
    parameter int STEP_HI_CYC     = 2,
    parameter int STEP_LO_CYC     = 4,
    parameter int STEPS_PER_CYCLE = 8,
    parameter int LOCK_WAIT       = 16,
    parameter int TIMEOUT         = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic        req_dir,
    input  logic [7:0]  req_steps,
    input  logic        locked,
    output logic [1:0]  phasesel,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] phase_pos,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STEP_HI = 3'd2,
        S_STEP_LO = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    // The settle counters must be able to hold TIMEOUT. LOCK_WAIT is below
    // TIMEOUT, so one width covers both.
    localparam int ST_W = $clog2(TIMEOUT + 1);

    localparam logic [15:0]     SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0]     HI_LAST    = 16'(STEP_HI_CYC - 1);
    localparam logic [15:0]     LO_LAST    = 16'(STEP_LO_CYC - 1);
    localparam logic [ST_W-1:0] LOCK_GOAL  = ST_W'(LOCK_WAIT);
    localparam logic [ST_W-1:0] TIME_GOAL  = ST_W'(TIMEOUT);
    // STEPS_PER_CYCLE is a power of two, so wrapping reduces to a mask.
    localparam logic [7:0]      POS_MASK   = 8'(STEPS_PER_CYCLE - 1);

    state_e            state_q;
    logic [1:0]        sel_q;
    logic              dir_q;
    logic [7:0]        rem_q;
    logic [15:0]       phase_cnt_q;
    logic [ST_W-1:0]   lock_cnt_q;
    logic [ST_W-1:0]   tot_cnt_q;
    logic [3:0][7:0]   pos_q;
    logic              phasestep_q;
    logic              phaseloadreg_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [ST_W-1:0]   lock_cnt_d;
    logic [ST_W-1:0]   tot_cnt_d;
    logic [7:0]        pos_cur;
    logic [7:0]        pos_d;

    assign req_ready    = (state_q == S_IDLE) && locked;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = phasestep_q;
    assign phaseloadreg = phaseloadreg_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign phase_pos    = pos_q;
    assign state_dbg_o  = state_q;

    always_comb begin
        // A single low cycle restarts the consecutive-lock count.
        lock_cnt_d = locked ? lock_cnt_q + 1'b1 : '0;
        tot_cnt_d  = tot_cnt_q + 1'b1;
        pos_cur    = pos_q[sel_q];
        pos_d      = (dir_q ? pos_cur - 8'd1 : pos_cur + 8'd1) & POS_MASK;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            sel_q          <= '0;
            dir_q          <= 1'b0;
            rem_q          <= '0;
            phase_cnt_q    <= '0;
            lock_cnt_q     <= '0;
            tot_cnt_q      <= '0;
            pos_q          <= '0;
            phasestep_q    <= 1'b0;
            phaseloadreg_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // These two are single-cycle strobes. They are re-asserted only on entry.
            done_q         <= 1'b0;
            phaseloadreg_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        sel_q          <= req_sel;
                        dir_q          <= req_dir;
                        rem_q          <= req_steps;
                        phase_cnt_q    <= '0;
                        phaseloadreg_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_cnt_q == SETUP_LAST) begin
                        phase_cnt_q <= '0;
                        if (rem_q == 8'd0) begin
                            lock_cnt_q <= '0;
                            tot_cnt_q  <= '0;
                            state_q    <= S_SETTLE;
                        end else begin
                            phasestep_q <= 1'b1;
                            state_q     <= S_STEP_HI;
                        end
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 16'd1;
                    end
                end
                S_STEP_HI: begin
                    if (phase_cnt_q == HI_LAST) begin
                        // A step counts as done when its high phase ends.
                        phase_cnt_q   <= '0;
                        phasestep_q   <= 1'b0;
                        rem_q         <= rem_q - 8'd1;
                        pos_q[sel_q]  <= pos_d;
                        state_q       <= S_STEP_LO;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 16'd1;
                    end
                end
                S_STEP_LO: begin
                    if (phase_cnt_q == LO_LAST) begin
                        phase_cnt_q <= '0;
                        if (rem_q != 8'd0) begin
                            phasestep_q <= 1'b1;
                            state_q     <= S_STEP_HI;
                        end else begin
                            lock_cnt_q <= '0;
                            tot_cnt_q  <= '0;
                            state_q    <= S_SETTLE;
                        end
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    lock_cnt_q <= lock_cnt_d;
                    tot_cnt_q  <= tot_cnt_d;
                    // The lock check comes first, so success wins a tie with timeout.
                    if (lock_cnt_d == LOCK_GOAL) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (tot_cnt_d == TIME_GOAL) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    phasestep_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_phase_step_ctrl.md
Name: pll_phase_step_ctrl

Overview:
- Sequences dynamic phase-shift requests into the ecp5pll phase ports (phasesel, phasedir, phasestep, phaseloadreg) for the HDMI/pixel/CPU clock generator.
- Runs on the 25 MHz PLL reference clock.
- Accepts one request at a time (output select, direction, step count) and emits correctly spaced phase-step pulses.
- Waits for PLL lock to settle, then reports completion and tracks the accumulated phase position of each output.

Parameters:
- SETUP_CYC, 2, cycles phasesel/phasedir are held stable before the first phasestep pulse (>=1).
- STEP_HI_CYC, 2, cycles phasestep is held high per step (>=1).
- STEP_LO_CYC, 4, cycles phasestep is held low between steps and after the last step (>=1).
- STEPS_PER_CYCLE, 8, phase steps per full output period; position counters wrap at this value (power of two, 2..256).
- LOCK_WAIT, 16, consecutive locked-high cycles required before done (>=1).
- TIMEOUT, 1024, maximum cycles in SETTLE before aborting with error (> LOCK_WAIT).

Ports:
- clk_i  in  1  25 MHz reference clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  controller can accept a request.
- req_sel  in  2  target output 0..3 (clocks[0..3]).
- req_dir  in  1  0 = advance phase (+), 1 = retard phase (-).
- req_steps  in  8  number of steps; 0 is legal.
- locked  in  1  PLL lock indicator; asynchronous to clk_i usage is not required.
- phasesel  out  2  to ecp5pll.
- phasedir  out  1  to ecp5pll.
- phasestep  out  1  to ecp5pll.
- phaseloadreg  out  1  to ecp5pll.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sampled with done; 1 = lock timeout.
- phase_pos  out  32  four 8-bit position counters; output n occupies [8n+7:8n].

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, except req_ready, which follows lock state from the first clock (0 while locked is low).
  - phase_pos is all 0. The FSM is in IDLE.
- req_ready = (state == IDLE) && locked.
- A transfer occurs when req_valid && req_ready on a rising edge:
  - sel, dir and steps are latched.
  - phasesel and phasedir are driven from the latched values on the next cycle and held constant until the FSM returns to IDLE.
- IDLE -> SETUP on transfer.
- SETUP: phaseloadreg is high for the first SETUP cycle only; phasestep is 0. After SETUP_CYC cycles:
  - if steps == 0 -> SETTLE;
  - otherwise -> STEP_HI.
- STEP_HI: phasestep = 1 for STEP_HI_CYC cycles, then -> STEP_LO.
  - On the STEP_HI -> STEP_LO edge, the remaining counter decrements.
  - In the same cycle, phase_pos[sel] updates by +1 (dir = 0) or -1 (dir = 1), modulo STEPS_PER_CYCLE. This gives wrap STEPS_PER_CYCLE-1 -> 0 on +1, and 0 -> STEPS_PER_CYCLE-1 on -1.
- STEP_LO: phasestep = 0 for STEP_LO_CYC cycles. Then:
  - remaining != 0 -> STEP_HI;
  - remaining == 0 -> SETTLE.
- SETTLE: counts consecutive cycles with locked = 1; any locked = 0 clears the count.
  - Count reaches LOCK_WAIT -> DONE with err = 0.
  - Total cycles in SETTLE reach TIMEOUT -> DONE with err = 1.
  - If both happen in the same cycle, success wins.
- DONE: one cycle, with done = 1 and err valid; then -> IDLE. err holds its value until the next done.
- Exact pulse count is required: exactly req_steps rising edges of phasestep per request.
- Duration: busy is high for SETUP_CYC + steps*(STEP_HI_CYC+STEP_LO_CYC) + settle + 1 cycles.
- Requests while busy are ignored (req_ready = 0); req_valid need not be held.
- Loss of lock during SETUP/STEP_HI/STEP_LO does not abort pulsing; it only affects SETTLE.
- Reset mid-operation:
  - phasestep drops to 0 immediately (asynchronously).
  - phase_pos clears to 0.
  - No done pulse is issued.
- phase_pos is a bookkeeping value only. It is not re-synchronised to hardware after reset.

Test Plan:
- Reset with locked = 1, then req sel = 1, dir = 0, steps = 3 (defaults) -> phaseloadreg pulse 1 cycle; exactly 3 phasestep pulses, each 2 high / 4 low; phasesel = 1 held throughout; done after 16 lock cycles with err = 0; phase_pos[15:8] = 3.
- Starting from pos[15:8] = 3, req sel = 1, dir = 1, steps = 5 -> phase_pos[15:8] = 6 (wrap 0 -> 7); other bytes unchanged.
- req steps = 0 -> no phasestep edges; busy = 2 + 16 + 1 cycles; done with err = 0; phase_pos unchanged.
- Force locked = 0 throughout SETTLE -> done at SETTLE cycle 1024 with err = 1. Separately, toggle locked low at SETTLE cycle 10 -> done only after 16 further consecutive high cycles.
- req_valid asserted while busy, and while locked = 0 in IDLE -> req_ready = 0 and no transfer. Back-to-back valid after done -> accepted on the first IDLE cycle.
- Assert rst_ni during the second STEP_HI of an 8-step request -> phasestep = 0 the same cycle; all outputs at reset values; no done; new request after release behaves as scenario 1.
